// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency byte-addressed big-endian memory responder with one outstanding request
// Illegal size, misalignment, out-of-range access or both enables set produce resp_err and leave memory untouched.
module data_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] address,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [63:0] write_data,
    input  logic [3:0]  xfer_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] read_data,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, nxt;
    logic [3:0] cnt;
    logic [63:0] a_q, wd_q, a_c, wd_c, rd, wal;
    logic [3:0] sz_q, sz_c;
    logic we_q, re_q, we_c, re_c, acc, enter, legal;
    logic [6:0] sh;
    logic [7:0] mem [2**ADDR_BITS];
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
    assign acc = req_valid && state == IDLE;
    // With LATENCY==1 the access happens on the accepting edge, so use the live inputs then
    assign a_c  = state == IDLE ? address : a_q;
    assign wd_c = state == IDLE ? write_data : wd_q;
    assign sz_c = state == IDLE ? xfer_size : sz_q;
    assign we_c = state == IDLE ? write_enable : we_q;
    assign re_c = state == IDLE ? read_enable : re_q;
    assign legal = (sz_c inside {4'd1, 4'd2, 4'd4, 4'd8})
                && ((a_c & (64'(sz_c) - 64'd1)) == 64'd0)
                && ({1'b0, a_c} + 65'(sz_c) <= (65'd1 << ADDR_BITS))
                && !(we_c && re_c);
    assign sh  = 7'(64 - 8 * int'(sz_c));
    assign wal = wd_c << sh;
    always_comb begin
        nxt = state;
        if (state == IDLE && req_valid) nxt = LATENCY == 1 ? RESP : WAIT;
        else if (state == WAIT && cnt == 4'd1) nxt = RESP;
        else if (state == RESP && resp_ready) nxt = IDLE;
    end
    assign enter = nxt == RESP && state != RESP;
    always_comb begin
        rd = '0;
        for (int i = 0; i < 8; i++)
            if (i < int'(sz_c)) rd = {rd[55:0], mem[ADDR_BITS'(a_c + 64'(i))]};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            read_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= nxt;
            if (acc) cnt <= 4'(LATENCY - 1);
            else if (state == WAIT) cnt <= cnt - 4'd1;
            if (enter) begin
                read_data <= legal && re_c && !we_c ? rd : '0;
                resp_err  <= !legal;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (acc) begin
            a_q  <= address;
            wd_q <= write_data;
            sz_q <= xfer_size;
            we_q <= write_enable;
            re_q <= read_enable;
        end
        if (enter && !reset && legal && we_c)
            for (int i = 0; i < 8; i++)
                if (i < int'(sz_c)) mem[ADDR_BITS'(a_c + 64'(i))] <= wal[63 - 8 * i -: 8];
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scenarios with hand-computed expectations for data_mem_responder
module tb_data_mem_responder;
    logic        clk = 0, reset = 1, req_valid = 0, req_ready, write_enable = 0, read_enable = 0;
    logic        resp_valid, resp_ready = 0, resp_err;
    logic [63:0] address = 0, write_data = 0, read_data;
    logic [3:0]  xfer_size = 0;
    int checks = 0, errors = 0;
    data_mem_responder dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .address(address), .write_enable(write_enable), .read_enable(read_enable),
        .write_data(write_data), .xfer_size(xfer_size), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .read_data(read_data), .resp_err(resp_err)
    );
    always #5 clk = ~clk;

    task automatic xact(input logic w, r, input logic [63:0] a, d, input logic [3:0] s,
                        output logic [63:0] rd, output logic e);
        int lat;
        req_valid = 1; write_enable = w; read_enable = r; address = a; write_data = d; xfer_size = s;
        @(posedge clk); #1;
        req_valid = 0; write_enable = ~w; read_enable = ~r; address = ~a; write_data = ~d; xfer_size = 4'd8;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL latency a=%h: got %0d want 2", a, lat); end
        rd = read_data; e = resp_err;
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_drop a=%h: got %b want 0", a, resp_valid); end
    endtask

    task automatic test_reset;
        checks++;
        if ({req_ready, resp_valid, resp_err, read_data} !== {3'b100, 64'd0}) begin
            errors++; $display("FAIL reset: rdy=%b vld=%b err=%b rd=%h want 1 0 0 0", req_ready, resp_valid, resp_err, read_data);
        end
    endtask

    task automatic test_store_load;
        logic [63:0] rd; logic e;
        xact(1, 0, 64'h10, 64'h0123456789ABCDEF, 8, rd, e);
        checks++;
        if ({e, rd} !== 65'd0) begin errors++; $display("FAIL store8 resp: err=%b rd=%h want 0 0", e, rd); end
        xact(0, 1, 64'h10, 0, 8, rd, e);
        checks++;
        if ({e, rd} !== {1'b0, 64'h0123456789ABCDEF}) begin errors++; $display("FAIL load8: err=%b rd=%h want 0 0123456789abcdef", e, rd); end
        xact(0, 1, 64'h10, 0, 1, rd, e);
        checks++;
        if ({e, rd} !== {1'b0, 64'h01}) begin errors++; $display("FAIL load1: err=%b rd=%h want 0 01", e, rd); end
        xact(0, 1, 64'h16, 0, 2, rd, e);
        checks++;
        if ({e, rd} !== {1'b0, 64'hCDEF}) begin errors++; $display("FAIL load2: err=%b rd=%h want 0 cdef", e, rd); end
        xact(0, 1, 64'h14, 0, 4, rd, e);
        checks++;
        if ({e, rd} !== {1'b0, 64'h89ABCDEF}) begin errors++; $display("FAIL load4: err=%b rd=%h want 0 89abcdef", e, rd); end
        xact(1, 0, 64'h13, 64'hFFFF_FFFF_FFFF_FFFF, 1, rd, e);
        xact(0, 1, 64'h10, 0, 8, rd, e);
        checks++;
        if (rd !== 64'h012345FF89ABCDEF) begin errors++; $display("FAIL byte_merge: got %h want 012345ff89abcdef", rd); end
    endtask

    task automatic test_errors;
        logic [63:0] rd; logic e;
        xact(1, 0, 64'h12, 64'h1111_1111_1111_1111, 4, rd, e);
        checks++;
        if ({e, rd} !== {1'b1, 64'd0}) begin errors++; $display("FAIL unaligned: err=%b rd=%h want 1 0", e, rd); end
        xact(1, 0, 64'h0, 64'h2222_2222_2222_2222, 3, rd, e);
        checks++;
        if ({e, rd} !== {1'b1, 64'd0}) begin errors++; $display("FAIL size3: err=%b rd=%h want 1 0", e, rd); end
        xact(0, 1, 64'h3FC, 0, 8, rd, e);
        checks++;
        if ({e, rd} !== {1'b1, 64'd0}) begin errors++; $display("FAIL over_end: err=%b rd=%h want 1 0", e, rd); end
        xact(1, 1, 64'h10, 64'h3333_3333_3333_3333, 8, rd, e);
        checks++;
        if ({e, rd} !== {1'b1, 64'd0}) begin errors++; $display("FAIL both_en: err=%b rd=%h want 1 0", e, rd); end
        xact(0, 1, 64'h400, 0, 1, rd, e);
        checks++;
        if ({e, rd} !== {1'b1, 64'd0}) begin errors++; $display("FAIL oob: err=%b rd=%h want 1 0", e, rd); end
        xact(0, 0, 64'h10, 64'h4444_4444_4444_4444, 8, rd, e);
        checks++;
        if ({e, rd} !== 65'd0) begin errors++; $display("FAIL noop: err=%b rd=%h want 0 0", e, rd); end
        xact(0, 1, 64'h10, 0, 8, rd, e);
        checks++;
        if (rd !== 64'h012345FF89ABCDEF) begin errors++; $display("FAIL unchanged: got %h want 012345ff89abcdef", rd); end
        xact(0, 1, 64'h0, 0, 8, rd, e);
        xact(0, 1, 64'h0, 0, 8, rd, e);
        xact(1, 0, 64'h3F8, 64'h1122334455667788, 8, rd, e);
        xact(0, 1, 64'h3FF, 0, 1, rd, e);
        checks++;
        if ({e, rd} !== {1'b0, 64'h88}) begin errors++; $display("FAIL top_byte: err=%b rd=%h want 0 88", e, rd); end
    endtask

    task automatic test_backpressure;
        logic [63:0] rd; logic e; int lat; logic bad;
        req_valid = 1; write_enable = 0; read_enable = 1; address = 64'h10; xfer_size = 2;
        @(posedge clk); #1;
        req_valid = 0; read_enable = 0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL hold_latency: got %0d want 2", lat); end
        req_valid = 1; write_enable = 1; address = 64'h10; write_data = 0; xfer_size = 8;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if ({resp_valid, req_ready, resp_err, read_data} !== {3'b100, 64'h0123}) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL hold_stable: vld=%b rdy=%b err=%b rd=%h want 1 0 0 0123", resp_valid, req_ready, resp_err, read_data); end
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0; req_valid = 0; write_enable = 0;
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL hold_release: vld=%b rdy=%b want 0 1", resp_valid, req_ready); end
        bad = 0;
        repeat (3) begin @(posedge clk); #1; if (resp_valid !== 1'b0) bad = 1; end
        checks++;
        if (bad) begin errors++; $display("FAIL ghost_resp: resp_valid rose, want 0"); end
        xact(0, 1, 64'h10, 0, 8, rd, e);
        checks++;
        if (rd !== 64'h012345FF89ABCDEF) begin errors++; $display("FAIL ignored_req: got %h want 012345ff89abcdef", rd); end
    endtask

    task automatic test_reset_abort;
        logic [63:0] rd; logic e; logic bad;
        xact(1, 0, 64'h20, 64'hAAAA_AAAA_AAAA_AAAA, 8, rd, e);
        req_valid = 1; write_enable = 1; read_enable = 0; address = 64'h20; write_data = 64'h5555_5555_5555_5555; xfer_size = 8;
        @(posedge clk); #1;
        req_valid = 0; write_enable = 0; reset = 1;
        @(posedge clk); #1;
        reset = 0;
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL abort_state: vld=%b rdy=%b want 0 1", resp_valid, req_ready); end
        bad = 0;
        repeat (3) begin @(posedge clk); #1; if (resp_valid !== 1'b0) bad = 1; end
        checks++;
        if (bad) begin errors++; $display("FAIL abort_resp: resp_valid rose, want 0"); end
        xact(0, 1, 64'h20, 0, 8, rd, e);
        checks++;
        if (rd !== 64'hAAAA_AAAA_AAAA_AAAA) begin errors++; $display("FAIL abort_commit: got %h want aaaaaaaaaaaaaaaa", rd); end
        xact(0, 1, 64'h10, 0, 8, rd, e);
        checks++;
        if (rd !== 64'h012345FF89ABCDEF) begin errors++; $display("FAIL mem_retained: got %h want 012345ff89abcdef", rd); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        test_reset;
        test_store_load;
        test_errors;
        test_backpressure;
        test_reset_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
